// File: rtl/add_sub_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
//   NIBBLE_W : width of one adder slice
//   state_t  : controller states (ST_IDLE / ST_CALC / ST_DONE)
//   flags_t  : N/Z/C/V flag bundle produced with each result
package add_sub_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/add_4bit_ci.sv
// 4-bit adder slice with carry-in, purely combinational.
// Ports:
//   a, b   in  4  addends
//   ci     in  1  carry in
//   sum_c  out 4  sum nibble
//   co_c   out 1  carry out of bit 3
//   c3_c   out 1  carry into bit 3 (for signed overflow of the top slice)
module add_4bit_ci (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum_c,
    output logic       co_c,
    output logic       c3_c
);

    logic [3:0] low_c;
    logic [1:0] high_c;

    // Split at bit 3 so the carry into the MSB is visible.
    always_comb begin
        low_c  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
        high_c = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, low_c[3]};
        sum_c  = {high_c[0], low_c[2:0]};
        co_c   = high_c[1];
        c3_c   = low_c[3];
    end

endmodule

// File: rtl/add_sub_serial_16bit.sv
// Nibble-serial add/subtract unit: one 4-bit slice per clock, LSB first,
// carry chained between slices through a single time-multiplexed adder.
// Optional feature macro: ADD_SUB_SERIAL_SAT_EN (saturate result on overflow).
// Ports:
//   clk_i      in   1  clock
//   rst_i      in   1  synchronous active-high reset
//   valid_i    in   1  request valid, accepted when valid_i && ready_o
//   add_sub_i  in   1  0 = A+B, 1 = A-B
//   A_i, B_i   in   W  two's complement operands
//   ready_o    out  1  high only while idle
//   done_o     out  1  one-cycle completion pulse
//   S_o        out  W  result
//   C_o        out  1  carry out of MSB (subtract: 1 = no borrow)
//   N_o        out  1  result sign
//   Z_o        out  1  result is zero
//   V_o        out  1  signed overflow
module add_sub_serial_16bit
    import add_sub_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic                       add_sub_i,
    input  logic [NIBBLE_W*NIBBLES-1:0] A_i,
    input  logic [NIBBLE_W*NIBBLES-1:0] B_i,
    output logic                       ready_o,
    output logic                       done_o,
    output logic [NIBBLE_W*NIBBLES-1:0] S_o,
    output logic                       C_o,
    output logic                       N_o,
    output logic                       Z_o,
    output logic                       V_o
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t state_q;
    state_t state_d;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept_c;
    logic calc_c;
    logic last_c;
    logic ready_d;
    logic done_d;

    logic [NIBBLE_W-1:0] nib_sum_c;
    logic                nib_co_c;
    logic                nib_c3_c;
    logic [W-1:0]        sum_next_c;
    logic [W-1:0]        res_c;
    flags_t              flags_c;

`ifdef ADD_SUB_SERIAL_SAT_EN
    logic a_msb_q;
`endif

    // Single adder slice, fed from the low nibble of the operand shifters.
    add_4bit_ci u_add (
        .a     (a_q[NIBBLE_W-1:0]),
        .b     (b_q[NIBBLE_W-1:0]),
        .ci    (carry_q),
        .sum_c (nib_sum_c),
        .co_c  (nib_co_c),
        .c3_c  (nib_c3_c)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (valid_i) state_d = ST_CALC;
            ST_CALC: if (cnt_q == LAST_CNT) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control decode; ready/done are computed for the state being entered
    // so their registered copies line up with the state itself.
    always_comb begin
        accept_c = 1'b0;
        calc_c   = 1'b0;
        last_c   = 1'b0;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: accept_c = valid_i;
            ST_CALC: begin
                calc_c = 1'b1;
                last_c = (cnt_q == LAST_CNT);
            end
            default: ;
        endcase
        case (state_d)
            ST_IDLE: ready_d = 1'b1;
            ST_DONE: done_d  = 1'b1;
            default: ;
        endcase
    end

    // Partial sum shifts in from the top; after the last slice it is the full result.
    always_comb begin
        sum_next_c = (sum_q >> NIBBLE_W) | (W'(nib_sum_c) << (W - NIBBLE_W));
        res_c      = sum_next_c;
        flags_c.c  = nib_co_c;
        flags_c.v  = nib_c3_c ^ nib_co_c;
`ifdef ADD_SUB_SERIAL_SAT_EN
        if (flags_c.v) begin
            res_c = a_msb_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
        flags_c.n  = res_c[W-1];
        flags_c.z  = (res_c == '0);
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ready_o <= 1'b1;
            done_o  <= 1'b0;
            S_o     <= '0;
            C_o     <= 1'b0;
            N_o     <= 1'b0;
            Z_o     <= 1'b0;
            V_o     <= 1'b0;
`ifdef ADD_SUB_SERIAL_SAT_EN
            a_msb_q <= 1'b0;
`endif
        end else begin
            ready_o <= ready_d;
            done_o  <= done_d;
            if (accept_c) begin
                // Subtract is A + ~B + 1.
                a_q     <= A_i;
                b_q     <= B_i ^ {W{add_sub_i}};
                carry_q <= add_sub_i;
                cnt_q   <= '0;
`ifdef ADD_SUB_SERIAL_SAT_EN
                a_msb_q <= A_i[W-1];
`endif
            end else if (calc_c) begin
                a_q     <= a_q >> NIBBLE_W;
                b_q     <= b_q >> NIBBLE_W;
                sum_q   <= sum_next_c;
                carry_q <= nib_co_c;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (last_c) begin
                    S_o <= res_c;
                    C_o <= flags_c.c;
                    N_o <= flags_c.n;
                    Z_o <= flags_c.z;
                    V_o <= flags_c.v;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_sub_serial_16bit.sv
module tb_add_sub_serial_16bit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        add_sub_i;
    logic [15:0] A_i;
    logic [15:0] B_i;
    logic        ready_o;
    logic        done_o;
    logic [15:0] S_o;
    logic        C_o;
    logic        N_o;
    logic        Z_o;
    logic        V_o;

    int errors = 0;
    int checks = 0;

    add_sub_serial_16bit dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .add_sub_i (add_sub_i),
        .A_i       (A_i),
        .B_i       (B_i),
        .ready_o   (ready_o),
        .done_o    (done_o),
        .S_o       (S_o),
        .C_o       (C_o),
        .N_o       (N_o),
        .Z_o       (Z_o),
        .V_o       (V_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic; returns {c,n,z,v,s}.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic op);
        logic [16:0] full;
        logic [15:0] bp;
        logic [15:0] s;
        logic        v;
        bp   = op ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {16'd0, op};
        s    = full[15:0];
        v    = (a[15] == bp[15]) && (s[15] != a[15]);
`ifdef ADD_SUB_SERIAL_SAT_EN
        if (v) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {full[16], s[15], (s == 16'd0), v, s};
    endfunction

    logic [15:0] prev_s;

    // One operation; noise drives fresh operands with valid_i high while busy.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                          input logic [15:0] exp_s, input logic [3:0] exp_cnzv, input bit noise);
        int lat;
        @(negedge clk_i);
        check_eq("ready_idle", 32'(ready_o), 32'd1);
        prev_s    = S_o;
        valid_i   = 1'b1;
        add_sub_i = op;
        A_i       = a;
        B_i       = b;
        lat       = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            if (done_o) begin
                lat = k;
                break;
            end
            check_eq("ready_busy", 32'(ready_o), 32'd0);
            if (k == 2) check_eq("hold_busy", 32'(S_o), 32'(prev_s));
            if (noise) begin
                valid_i   = 1'b1;
                A_i       = 16'($urandom);
                B_i       = 16'($urandom);
                add_sub_i = 1'($urandom);
            end else begin
                valid_i = 1'b0;
            end
        end
        valid_i = 1'b0;
        check_eq("latency", 32'(lat), 32'd5);
        check_eq("ready_done", 32'(ready_o), 32'd0);
        check_eq("S", 32'(S_o), 32'(exp_s));
        check_eq("CNZV", 32'({C_o, N_o, Z_o, V_o}), 32'(exp_cnzv));
        @(negedge clk_i);
        check_eq("done_width", 32'(done_o), 32'd0);
        check_eq("S_hold", 32'(S_o), 32'(exp_s));
    endtask

    task automatic run_model(input logic [15:0] a, input logic [15:0] b, input logic op, input bit noise);
        logic [19:0] r;
        r = model(a, b, op);
        run_op(a, b, op, r[15:0], r[19:16], noise);
    endtask

    logic [15:0] da [7];
    logic [15:0] db [7];
    logic        dop[7];
    logic [15:0] ds [7];
    logic [3:0]  df [7];

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; add_sub_i = 1'b0; A_i = '0; B_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_ready", 32'(ready_o), 32'd1);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_S", 32'(S_o), 32'd0);
        check_eq("rst_CNZV", 32'({C_o, N_o, Z_o, V_o}), 32'd0);
        rst_i = 1'b0;

        // Directed vectors: flags are {C,N,Z,V}.
        da[0] = 16'h0001; db[0] = 16'h0002; dop[0] = 0; ds[0] = 16'h0003; df[0] = 4'b0000;
        da[1] = 16'h00FF; db[1] = 16'h0001; dop[1] = 0; ds[1] = 16'h0100; df[1] = 4'b0000;
        da[2] = 16'h0003; db[2] = 16'h0002; dop[2] = 1; ds[2] = 16'h0001; df[2] = 4'b1000;
        da[3] = 16'h1234; db[3] = 16'h1234; dop[3] = 1; ds[3] = 16'h0000; df[3] = 4'b1010;
        da[4] = 16'hFFFF; db[4] = 16'h0001; dop[4] = 0; ds[4] = 16'h0000; df[4] = 4'b1010;
`ifdef ADD_SUB_SERIAL_SAT_EN
        da[5] = 16'h7FFF; db[5] = 16'h0001; dop[5] = 0; ds[5] = 16'h7FFF; df[5] = 4'b0001;
        da[6] = 16'h8000; db[6] = 16'h0001; dop[6] = 1; ds[6] = 16'h8000; df[6] = 4'b1101;
`else
        da[5] = 16'h7FFF; db[5] = 16'h0001; dop[5] = 0; ds[5] = 16'h8000; df[5] = 4'b0101;
        da[6] = 16'h8000; db[6] = 16'h0001; dop[6] = 1; ds[6] = 16'h7FFF; df[6] = 4'b1001;
`endif
        for (int i = 0; i < 7; i++) run_op(da[i], db[i], dop[i], ds[i], df[i], 1'b0);

        // Operands changing with valid_i high during the calculation are ignored.
        run_model(16'h1357, 16'h2468, 1'b0, 1'b1);
        run_model(16'hABCD, 16'h1234, 1'b1, 1'b1);

        // Reset two cycles after accept.
        @(negedge clk_i);
        valid_i = 1'b1; add_sub_i = 1'b0; A_i = 16'h1111; B_i = 16'h2222;
        @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_eq("mid_rst_S", 32'(S_o), 32'd0);
        check_eq("mid_rst_CNZV", 32'({C_o, N_o, Z_o, V_o}), 32'd0);
        check_eq("mid_rst_done", 32'(done_o), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            check_eq("post_rst_ready", 32'(ready_o), 32'd1);
            check_eq("post_rst_done", 32'(done_o), 32'd0);
        end
        run_model(16'h4321, 16'h0FED, 1'b1, 1'b0);

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            run_model(16'($urandom), 16'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
